// File: rtl/sub16_serial.sv
// sub16_serial: bit-serial two's-complement subtractor.
//
// Computes A - B as A + ~B + 1 with a single full-adder slice, one bit per
// clock, LSB first, over NUMBITS cycles. The flag set is borrow, zero and
// signed overflow. A start/done handshake frames each operation.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous, active-high reset
//   start       operation request, sampled only while idle
//   A, B        minuend / subtrahend, captured on the accepting edge
//   busy        high while bits are being processed (NUMBITS cycles)
//   done        one-cycle pulse; diff and flags are valid from this cycle on
//   diff        A - B modulo 2^NUMBITS
//   borrowflag  1 when unsigned A < B (inverted final carry)
//   zero        1 when diff == 0
//   overflow    signed overflow of A - B
module sub16_serial #(
  parameter int unsigned NUMBITS = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [NUMBITS-1:0] A,
  input  logic [NUMBITS-1:0] B,
  output logic               busy,
  output logic               done,
  output logic [NUMBITS-1:0] diff,
  output logic               borrowflag,
  output logic               zero,
  output logic               overflow
);

  localparam int unsigned CntW = (NUMBITS > 2) ? $clog2(NUMBITS) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(NUMBITS - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e             state;
  logic [NUMBITS-1:0] ra;   // minuend, shifted right each bit
  logic [NUMBITS-1:0] rb;   // inverted subtrahend, shifted right each bit
  logic [NUMBITS-1:0] rr;   // result, filled from the MSB end
  logic               c;    // serial carry; starts at 1 to form the +1 of ~B + 1
  logic [CntW-1:0]    cnt;
  logic               sa;
  logic               sb;

  // Serial full-adder slice and the result as it will look after this edge.
  logic               s;
  logic               c_next;
  logic [NUMBITS-1:0] rr_next;

  always_comb begin
    s       = ra[0] ^ rb[0] ^ c;
    c_next  = (ra[0] & rb[0]) | (ra[0] & c) | (rb[0] & c);
    rr_next = {s, rr[NUMBITS-1:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= StIdle;
      ra         <= '0;
      rb         <= '0;
      rr         <= '0;
      c          <= 1'b0;
      cnt        <= '0;
      sa         <= 1'b0;
      sb         <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      diff       <= '0;
      borrowflag <= 1'b0;
      zero       <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          done <= 1'b0;
          if (start) begin
            ra    <= A;
            rb    <= ~B;
            rr    <= '0;
            c     <= 1'b1;
            cnt   <= '0;
            sa    <= A[NUMBITS-1];
            sb    <= B[NUMBITS-1];
            busy  <= 1'b1;
            state <= StRun;
          end
        end

        StRun: begin
          ra  <= ra >> 1;
          rb  <= rb >> 1;
          c   <= c_next;
          rr  <= rr_next;
          cnt <= cnt + 1'b1;
          if (cnt == LastCnt) begin
            // Outputs are only written here so they hold through later runs.
            state      <= StDone;
            busy       <= 1'b0;
            done       <= 1'b1;
            diff       <= rr_next;
            borrowflag <= ~c_next;
            zero       <= (rr_next == '0);
            overflow   <= (sa != sb) && (rr_next[NUMBITS-1] != sa);
          end
        end

        StDone: begin
          // DONE never accepts start; the earliest next accept is in IDLE.
          done  <= 1'b0;
          state <= StIdle;
        end

        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sub16_serial.sv
// Self-checking bench for sub16_serial (NUMBITS = 16): directed corner cases,
// start/operand-change handling, mid-run reset, then random operands checked
// against an arithmetic reference model.
module tb_sub16_serial;

  localparam int N = 16;

  logic          clk;
  logic          rst;
  logic          start;
  logic [N-1:0]  A;
  logic [N-1:0]  B;
  logic          busy;
  logic          done;
  logic [N-1:0]  diff;
  logic          borrowflag;
  logic          zero;
  logic          overflow;

  int n_vec;
  int n_err;

  sub16_serial #(
    .NUMBITS(N)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .A         (A),
    .B         (B),
    .busy      (busy),
    .done      (done),
    .diff      (diff),
    .borrowflag(borrowflag),
    .zero      (zero),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain modular and signed integer arithmetic.
  task automatic model(input logic [N-1:0] a, input logic [N-1:0] b,
                       output logic [N-1:0] d, output logic bo, output logic z,
                       output logic ov);
    int sa_i;
    int sb_i;
    int r;
    sa_i = int'($signed(a));
    sb_i = int'($signed(b));
    r    = sa_i - sb_i;
    d    = a - b;
    bo   = (a < b);
    z    = (d == '0);
    ov   = (r > 32767) || (r < -32768);
  endtask

  // Issue one operation (DUT must be idle) and check timing and results.
  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [N-1:0] ed;
    logic         eb;
    logic         ez;
    logic         eo;
    int           k;
    int           bc;
    model(a, b, ed, eb, ez, eo);
    @(negedge clk);
    A     = a;
    B     = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    A     = N'($urandom);
    B     = N'($urandom);
    bc    = 0;
    for (k = 1; k <= N + 5; k++) begin
      @(negedge clk);
      if (done) break;
      if (busy) bc++;
    end
    check("latency", 32'(k), 32'(N + 1));
    check("busy_cycles", 32'(bc), 32'(N));
    check("busy_in_done", 32'(busy), 32'(0));
    check("diff", 32'(diff), 32'(ed));
    check("borrowflag", 32'(borrowflag), 32'(eb));
    check("zero", 32'(zero), 32'(ez));
    check("overflow", 32'(overflow), 32'(eo));
    @(negedge clk);
    check("done_pulse", 32'(done), 32'(0));
    check("diff_hold", 32'(diff), 32'(ed));
  endtask

  initial begin
    int dones;
    n_vec = 0;
    n_err = 0;
    rst   = 1'b1;
    start = 1'b0;
    A     = '0;
    B     = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_diff", 32'(diff), 32'(0));
    check("rst_flags", 32'({borrowflag, zero, overflow}), 32'(0));
    rst = 1'b0;

    // Directed corner cases.
    run_op(16'd5, 16'd3);
    run_op(16'd3, 16'd5);
    run_op(16'h8000, 16'h0001);
    run_op(16'h7FFF, 16'hFFFF);
    run_op(16'h1234, 16'h1234);
    run_op(16'h0000, 16'h0000);
    run_op(16'hFFFF, 16'h0000);

    // start pulses in RUN and DONE are ignored; late operand changes ignored.
    @(negedge clk);
    A     = 16'd9;
    B     = 16'd4;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    dones = 0;
    for (int k = 1; k <= N + 21; k++) begin
      @(negedge clk);
      if (done) begin
        dones++;
        check("ign_done_time", 32'(k), 32'(N + 1));
        check("ign_diff", 32'(diff), 32'h0005);
      end
      start = (k == 3) || (k == 8) || (k == N + 1);
      A     = 16'hFFFF;
      B     = 16'h0000;
    end
    start = 1'b0;
    check("ign_done_count", 32'(dones), 32'(1));
    check("ign_diff_hold", 32'(diff), 32'h0005);

    // Reset in the middle of 100 - 1.
    @(negedge clk);
    A     = 16'd100;
    B     = 16'd1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (7) @(negedge clk);
    check("mid_busy", 32'(busy), 32'(1));
    rst = 1'b1;
    @(negedge clk);
    check("mrst_busy", 32'(busy), 32'(0));
    check("mrst_done", 32'(done), 32'(0));
    check("mrst_diff", 32'(diff), 32'(0));
    check("mrst_flags", 32'({borrowflag, zero, overflow}), 32'(0));
    rst   = 1'b0;
    dones = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("mrst_no_done", 32'(dones), 32'(0));
    run_op(16'd100, 16'd1);

    // Random operands, with extra weight on sign-boundary values.
    for (int i = 0; i < 120; i++) begin
      logic [N-1:0] ra;
      logic [N-1:0] rb;
      ra = N'($urandom);
      rb = N'($urandom);
      if ($urandom_range(0, 3) == 0) ra = {ra[0], {(N - 1){ra[1]}}};
      if ($urandom_range(0, 3) == 0) rb = {rb[0], {(N - 1){rb[1]}}};
      if ($urandom_range(0, 9) == 0) rb = ra;
      run_op(ra, rb);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
